// File: rtl/matmul_job_sequencer_pkg.sv
// Shared types and defaults for the matmul job sequencer: row geometry,
// one-hot FSM encoding and default job shape.
package matmul_pkg;

  localparam int unsigned ROW_W       = 40;
  localparam int unsigned LANE_W      = 8;
  localparam int unsigned LANES       = ROW_W / LANE_W;

  localparam int unsigned N_DEF       = 5;
  localparam int unsigned T_DEF       = 10;
  localparam int unsigned GAP_DEF     = 2;
  localparam int unsigned TIMEOUT_DEF = 64;

  typedef logic [ROW_W-1:0] row_t;

  typedef enum logic [7:0] {
    S_IDLE     = 8'b0000_0001,
    S_COLLECT  = 8'b0000_0010,
    S_SEND_W   = 8'b0000_0100,
    S_TERM_W   = 8'b0000_1000,
    S_SEND_I   = 8'b0001_0000,
    S_TERM_I   = 8'b0010_0000,
    S_WAIT_RES = 8'b0100_0000,
    S_GAP      = 8'b1000_0000
  } seq_state_t;

  // An all-zero row is the array's terminator, so it cannot appear as data.
  function automatic logic row_is_zero(input row_t r);
    return (r == '0);
  endfunction

endpackage

// File: rtl/matmul_job_sequencer_if.sv
// Requester, array and result signals of the job sequencer, bundled.
// slave = the sequencer itself, master = the surrounding environment.
interface matmul_job_sequencer_if;
  import matmul_pkg::*;

  logic [1:0] REQ_VALID_i;
  logic [1:0] REQ_READY_o;
  row_t       REQ_DATA0_i;
  row_t       REQ_DATA1_i;
  row_t       ARR_WEIGHT_o;
  row_t       ARR_IN_o;
  row_t       ARR_OUT_i;
  logic       ARR_VAL_i;
  logic       ARR_OV_i;
  logic       RES_VALID_o;
  row_t       RES_DATA_o;
  logic       RES_ID_o;
  logic       RES_LAST_o;
  logic       RES_OV_o;
  logic       ERR_o;
  logic       ERR_ID_o;
  logic       BUSY_o;

  modport slave (
    input  REQ_VALID_i, REQ_DATA0_i, REQ_DATA1_i, ARR_OUT_i, ARR_VAL_i, ARR_OV_i,
    output REQ_READY_o, ARR_WEIGHT_o, ARR_IN_o, RES_VALID_o, RES_DATA_o,
           RES_ID_o, RES_LAST_o, RES_OV_o, ERR_o, ERR_ID_o, BUSY_o
  );

  modport master (
    output REQ_VALID_i, REQ_DATA0_i, REQ_DATA1_i, ARR_OUT_i, ARR_VAL_i, ARR_OV_i,
    input  REQ_READY_o, ARR_WEIGHT_o, ARR_IN_o, RES_VALID_o, RES_DATA_o,
           RES_ID_o, RES_LAST_o, RES_OV_o, ERR_o, ERR_ID_o, BUSY_o
  );

endinterface

// File: rtl/matmul_job_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves to the other side each
// time a job from the granted side is accepted.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [1:0] req,
  input  logic       accept,
  input  logic       accept_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic ptr;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)       ptr <= 1'b0;
    else if (accept) ptr <= ~accept_id;
  end

  always_comb begin
    gnt_valid = |req;
    gnt_id    = req[ptr] ? ptr : ~ptr;
  end

endmodule

// File: rtl/matmul_job_sequencer.sv
// Buffers whole jobs from two requesters, streams them into the systolic
// array with zero-row terminators and returns tagged result rows.
module matmul_job_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned T       = T_DEF,
  parameter int unsigned GAP     = GAP_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  matmul_job_sequencer_if.slave bus
);

  localparam int unsigned ROWS = N + T;
  localparam int unsigned IW   = $clog2(ROWS + 1);
  localparam int unsigned WW   = $clog2(TIMEOUT + 1);
  localparam int unsigned GW   = $clog2(GAP + 1);

  seq_state_t    state, state_nx;
  logic          gid;
  logic [IW-1:0] idx, res_cnt;
  logic [WW-1:0] wd;
  logic [GW-1:0] gap_cnt;
  logic          bad, ov_acc;
  row_t          job_buf [ROWS];

  row_t req_row;
  logic accept, last_row, res_fire, res_done, wd_expire, err_set;
  logic gnt_valid, gnt_id;

  rr_arbiter2 u_arb (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .req       (bus.REQ_VALID_i),
    .accept    (last_row),
    .accept_id (gid),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    req_row   = gid ? bus.REQ_DATA1_i : bus.REQ_DATA0_i;
    accept    = (state == S_COLLECT) && bus.REQ_VALID_i[gid];
    last_row  = accept && (idx == IW'(ROWS - 1));
    res_fire  = (state == S_WAIT_RES) && bus.ARR_VAL_i;
    res_done  = res_fire && (res_cnt == IW'(T - 1));
    // A final result landing on the watchdog's last cycle still completes the job.
    wd_expire = (state == S_WAIT_RES) && !res_done && (wd == WW'(TIMEOUT - 1));
    err_set   = (last_row && (bad || row_is_zero(req_row))) || wd_expire;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (gnt_valid) state_nx = S_COLLECT;
      S_COLLECT:  if (last_row)  state_nx = err_set ? S_GAP : S_SEND_W;
      S_SEND_W:   if (idx == IW'(N - 1)) state_nx = S_TERM_W;
      S_TERM_W:   state_nx = S_SEND_I;
      S_SEND_I:   if (idx == IW'(T - 1)) state_nx = S_TERM_I;
      S_TERM_I:   state_nx = S_WAIT_RES;
      S_WAIT_RES: if (res_done || wd_expire) state_nx = S_GAP;
      S_GAP:      if (gap_cnt == GW'(GAP - 1)) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY_o       = (state != S_IDLE);
    bus.REQ_READY_o  = '0;
    bus.ARR_WEIGHT_o = '0;
    bus.ARR_IN_o     = '0;
    if (state == S_COLLECT) bus.REQ_READY_o = gid ? 2'b10 : 2'b01;
    if (state == S_SEND_W)  bus.ARR_WEIGHT_o = job_buf[idx];
    if (state == S_SEND_I)  bus.ARR_IN_o = job_buf[idx + IW'(N)];
  end

  always_ff @(posedge CLK) begin
    if (accept) job_buf[idx] <= req_row;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      gid             <= 1'b0;
      idx             <= '0;
      res_cnt         <= '0;
      wd              <= '0;
      gap_cnt         <= '0;
      bad             <= 1'b0;
      ov_acc          <= 1'b0;
      bus.RES_VALID_o <= 1'b0;
      bus.RES_DATA_o  <= '0;
      bus.RES_ID_o    <= 1'b0;
      bus.RES_LAST_o  <= 1'b0;
      bus.RES_OV_o    <= 1'b0;
      bus.ERR_o       <= 1'b0;
      bus.ERR_ID_o    <= 1'b0;
    end else begin
      if (state == S_IDLE && gnt_valid) gid <= gnt_id;

      if (state_nx != state) idx <= '0;
      else if (accept || state == S_SEND_W || state == S_SEND_I) idx <= idx + 1'b1;

      res_cnt <= (state != S_WAIT_RES) ? '0 : (res_fire ? res_cnt + 1'b1 : res_cnt);
      wd      <= (state == S_WAIT_RES) ? wd + 1'b1 : '0;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      ov_acc  <= (state == S_IDLE || state == S_GAP) ? 1'b0 : (ov_acc | bus.ARR_OV_i);

      if (state == S_IDLE)                        bad <= 1'b0;
      else if (accept && row_is_zero(req_row))    bad <= 1'b1;

      bus.RES_VALID_o <= res_fire;
      bus.RES_DATA_o  <= res_fire ? bus.ARR_OUT_i : '0;
      bus.RES_ID_o    <= res_fire & gid;
      bus.RES_LAST_o  <= res_done;
      bus.RES_OV_o    <= res_done & (ov_acc | bus.ARR_OV_i);
      bus.ERR_o       <= err_set;
      bus.ERR_ID_o    <= err_set & gid;
    end
  end

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Directed bench for matmul_job_sequencer: table of whole jobs plus
// hand-written arbitration and mid-job reset sequences.
module tb_matmul_job_sequencer;
  import matmul_pkg::*;

  localparam int unsigned N = 5, T = 10, GAP = 2, TIMEOUT = 64;
  localparam int unsigned ROWS = N + T;
  localparam row_t RES_PAT = 40'h0F0F0F0F0F;

  typedef row_t job_t [ROWS];
  typedef struct {
    bit   id;
    row_t w;
    row_t i;
    int   bad;     // index of zeroed row, -1 for none
    int   nres;    // results the array model returns
    int   ov_idx;  // 1-based result carrying ARR_OV_i, 0 for none
    bit   e_err;
    int   e_res;
    bit   e_last;
    bit   e_ov;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic v0 = 1'b0, v1 = 1'b0;
  row_t d0 = '0, d1 = '0;

  matmul_job_sequencer_if bus ();
  assign bus.REQ_VALID_i = {v1, v0};
  assign bus.REQ_DATA0_i = d0;
  assign bus.REQ_DATA1_i = d1;

  matmul_job_sequencer #(.N(N), .T(T), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Array model: after the input terminator, return arr_nres result rows.
  int arr_nres = 10;
  int arr_ov_idx = 0;
  initial begin : array_model
    bit prev_nz;
    prev_nz = 1'b0;
    bus.ARR_VAL_i = 1'b0;
    bus.ARR_OV_i  = 1'b0;
    bus.ARR_OUT_i = '0;
    forever begin
      @(negedge clk);
      if (prev_nz && bus.ARR_IN_o == '0 && bus.BUSY_o) begin
        prev_nz = 1'b0;
        for (int r = 1; r <= arr_nres; r++) begin
          @(posedge clk); #1;
          bus.ARR_VAL_i = 1'b1;
          bus.ARR_OUT_i = RES_PAT;
          bus.ARR_OV_i  = (r == arr_ov_idx);
        end
        @(posedge clk); #1;
        bus.ARR_VAL_i = 1'b0;
        bus.ARR_OV_i  = 1'b0;
        bus.ARR_OUT_i = '0;
      end else begin
        prev_nz = (bus.ARR_IN_o != '0);
      end
    end
  end

  // Passive monitor, sampled on the falling edge.
  int   cyc = 0, err_n = 0, err_cyc = 0, term_cyc = 0, evt_cyc = 0;
  int   idle_cyc = 0, idle_n = 0, traffic_n = 0, overlap_n = 0;
  logic err_id_last = 1'b0;
  logic res_id_q [$];
  row_t res_data_q [$];
  logic res_last_q [$];
  logic res_ov_q [$];
  logic grant_q [$];
  logic prev_busy = 1'b0;
  row_t prev_in = '0;
  logic [1:0] prev_ready = '0;

  always @(negedge clk) begin
    if (bus.RES_VALID_o) begin
      res_id_q.push_back(bus.RES_ID_o);
      res_data_q.push_back(bus.RES_DATA_o);
      res_last_q.push_back(bus.RES_LAST_o);
      res_ov_q.push_back(bus.RES_OV_o);
      if (bus.RES_LAST_o) evt_cyc <= cyc;
    end
    if (bus.ERR_o) begin
      err_n       <= err_n + 1;
      err_cyc     <= cyc;
      evt_cyc     <= cyc;
      err_id_last <= bus.ERR_ID_o;
    end
    if (bus.BUSY_o && prev_in != '0 && bus.ARR_IN_o == '0) term_cyc <= cyc;
    if (prev_busy && !bus.BUSY_o) begin
      idle_cyc <= cyc;
      idle_n   <= idle_n + 1;
    end
    if (bus.ARR_WEIGHT_o != '0 || bus.ARR_IN_o != '0) traffic_n <= traffic_n + 1;
    if (bus.REQ_READY_o == 2'b11) overlap_n <= overlap_n + 1;
    if (prev_ready == 2'b00 && bus.REQ_READY_o != 2'b00) grant_q.push_back(bus.REQ_READY_o[1]);
    prev_busy  <= bus.BUSY_o;
    prev_in    <= bus.ARR_IN_o;
    prev_ready <= bus.REQ_READY_o;
    cyc        <= cyc + 1;
  end

  task automatic build_rows(input row_t w, input row_t i, input int bad, output job_t r);
    for (int k = 0; k < int'(ROWS); k++) r[k] = (k < int'(N)) ? w : i;
    if (bad >= 0) r[bad] = '0;
  endtask

  task automatic send_job(input bit id, input job_t rows);
    for (int k = 0; k < int'(ROWS); k++) begin
      bit got;
      if (id) begin d1 = rows[k]; v1 = 1'b1; end
      else    begin d0 = rows[k]; v0 = 1'b1; end
      got = 1'b0;
      for (int n = 0; n < 2000 && !got; n++) begin
        @(negedge clk);
        got = bus.REQ_READY_o[id];
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL send_job%0d: ready never came for row %0d", id, k);
        if (id) v1 = 1'b0; else v0 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (id) v1 = 1'b0; else v0 = 1'b0;
  endtask

  // Expected array drive right after collection: 5 weights, zero, 10 inputs, zero.
  task automatic check_stream(input job_t rows, input int v);
    for (int c = 0; c < int'(ROWS) + 2; c++) begin
      row_t ew, ei;
      ew = '0;
      ei = '0;
      if (c < int'(N)) ew = rows[c];
      else if (c > int'(N) && c <= int'(ROWS)) ei = rows[c-1];
      @(negedge clk);
      chk_row($sformatf("stream v%0d c%0d", v, c), {bus.ARR_WEIGHT_o, bus.ARR_IN_o}, {ew, ei});
    end
  endtask

  task automatic wait_idle(input int target);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      done = (idle_n >= target);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy_fall count %0d expected %0d", idle_n, target);
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog");
  end

  initial begin : main
    vec_t vt [6];
    job_t rows, rows_b;
    int rb, eb, ib, tb0, gb, ob, nlast, nbad_id, nbad_data;
    logic ov_seen;
    logic [2:0] order;

    vt[0] = '{1'b0, 40'h0102030405, 40'h0101010101, -1, 10, 0, 1'b0, 10, 1'b1, 1'b0};
    vt[1] = '{1'b1, 40'h1112131415, 40'h0A0A0A0A0A,  7, 10, 0, 1'b1,  0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 40'h2122232425, 40'h0203040506, -1, 10, 0, 1'b0, 10, 1'b1, 1'b0};
    vt[3] = '{1'b1, 40'h0102030405, 40'h0101010101, -1,  4, 0, 1'b1,  4, 1'b0, 1'b0};
    vt[4] = '{1'b0, 40'h0102030405, 40'h0101010101, -1, 10, 3, 1'b0, 10, 1'b1, 1'b1};
    vt[5] = '{1'b1, 40'h7F7F7F7F7F, 40'h8081828384, -1, 10, 0, 1'b0, 10, 1'b1, 1'b0};

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", int'({bus.REQ_READY_o, bus.BUSY_o, bus.ERR_o, bus.ERR_ID_o,
                            bus.RES_VALID_o, bus.RES_ID_o, bus.RES_LAST_o, bus.RES_OV_o}), 0);
    chk_row("reset_arr", {bus.ARR_WEIGHT_o, bus.ARR_IN_o}, '0);
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      rb  = res_id_q.size();
      eb  = err_n;
      ib  = idle_n;
      tb0 = traffic_n;
      arr_nres   = vt[v].nres;
      arr_ov_idx = vt[v].ov_idx;
      build_rows(vt[v].w, vt[v].i, vt[v].bad, rows);
      send_job(vt[v].id, rows);
      if (vt[v].bad < 0) check_stream(rows, v);
      wait_idle(ib + 1);

      nlast = 0; nbad_id = 0; nbad_data = 0; ov_seen = 1'b0;
      for (int k = rb; k < res_id_q.size(); k++) begin
        if (res_last_q[k]) nlast++;
        if (res_id_q[k] !== vt[v].id) nbad_id++;
        if (res_data_q[k] !== RES_PAT) nbad_data++;
        ov_seen = ov_seen | res_ov_q[k];
      end
      chk($sformatf("v%0d err_count", v), err_n - eb, int'(vt[v].e_err));
      if (vt[v].e_err) chk($sformatf("v%0d err_id", v), int'(err_id_last), int'(vt[v].id));
      chk($sformatf("v%0d res_count", v), res_id_q.size() - rb, vt[v].e_res);
      chk($sformatf("v%0d last_count", v), nlast, int'(vt[v].e_last));
      chk($sformatf("v%0d res_ov", v), int'(ov_seen), int'(vt[v].e_ov));
      chk($sformatf("v%0d res_id_mismatch", v), nbad_id, 0);
      chk($sformatf("v%0d res_data_mismatch", v), nbad_data, 0);
      chk($sformatf("v%0d array_traffic", v), traffic_n - tb0, (vt[v].bad >= 0) ? 0 : int'(ROWS));
      chk($sformatf("v%0d gap_cycles", v), idle_cyc - evt_cyc, int'(GAP));
      if (vt[v].bad < 0 && vt[v].nres < int'(T))
        chk($sformatf("v%0d timeout_latency", v), err_cyc - term_cyc, int'(TIMEOUT) + 1);
    end

    // Simultaneous requests after reset, then req0 back-to-back with req1 pending.
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    arr_nres = 10; arr_ov_idx = 0;
    rb = res_id_q.size(); gb = grant_q.size(); ob = overlap_n; ib = idle_n; tb0 = traffic_n;
    build_rows(40'h0102030405, 40'h0101010101, -1, rows);
    build_rows(40'h0504030201, 40'h0303030303, -1, rows_b);
    fork
      begin send_job(1'b0, rows); send_job(1'b0, rows); end
      begin send_job(1'b1, rows_b); end
    join
    wait_idle(ib + 3);
    chk("rr_grant_count", grant_q.size() - gb, 3);
    order = 3'b111;
    if (grant_q.size() >= gb + 3) order = {grant_q[gb], grant_q[gb+1], grant_q[gb+2]};
    chk("rr_grant_order", int'(order), 3'b010);
    chk("rr_ready_overlap", overlap_n - ob, 0);
    chk("rr_traffic", traffic_n - tb0, 3 * int'(ROWS));
    chk("rr_res_count", res_id_q.size() - rb, 3 * int'(T));
    nbad_id = 0;
    for (int k = rb; k < res_id_q.size(); k++)
      if (res_id_q[k] !== ((k - rb) / int'(T) == 1)) nbad_id++;
    chk("rr_res_id_order", nbad_id, 0);

    // Reset asserted while the input rows are streaming.
    eb = err_n; rb = res_id_q.size();
    send_job(1'b0, rows);
    begin
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
        @(negedge clk);
        seen = (bus.ARR_IN_o != '0);
      end
      chk("midrst_reached_send_i", int'(seen), 1);
    end
    #2 rstn = 1'b0;
    #1;
    chk("midrst_ctrl", int'({bus.REQ_READY_o, bus.BUSY_o, bus.ERR_o, bus.ERR_ID_o,
                             bus.RES_VALID_o, bus.RES_ID_o, bus.RES_LAST_o, bus.RES_OV_o}), 0);
    chk_row("midrst_arr", {bus.ARR_WEIGHT_o, bus.ARR_IN_o}, '0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_err", err_n - eb, 0);
    chk("midrst_no_res", res_id_q.size() - rb, 0);
    chk("midrst_idle", int'(bus.BUSY_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
